// File: rtl/jtag_pkg.sv
// Shared TAP definitions: the 16-state TAP encoding, the fixed instruction
// opcodes and the low bits loaded into the IR shift register on capture.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_t;

    localparam int unsigned OP_EXTEST = 32'd0;
    localparam int unsigned OP_SAMPLE = 32'd1;
    localparam int unsigned OP_IDCODE = 32'd2;

    // Upper IR capture bits are zero; only these two LSBs are fixed.
    localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_tap_ctrl_tap_fsm.sv
// TAP state machine: walks the 16 states on TMS and returns the current state.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst_n,
    input  logic       tms,
    output tap_state_t state
);

    tap_state_t state_q, state_d;

    // State register; TRST forces TEST_LOGIC_RESET immediately.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode following the standard TAP diagram.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, bypass/ID data registers, boundary-scan chain controls, TDO mux.
// Optional macro JTAG_IDCODE_EN adds the 32-bit ID register and makes IDCODE the reset instruction.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic                bsc_s_i,
    input  logic                bsc_s_o,
    output logic                bsc_clock_dr,
    output logic                bsc_shift_dr,
    output logic                bsc_update_dr,
    output logic                bsc_enable,
    output logic                bsc_mode,
    output logic [IR_WIDTH-1:0] ir_value
);

    localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OP_EXTEST);
    localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OP_SAMPLE);
    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = {IR_WIDTH{1'b1}};
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE_LSBS};
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_IDCODE;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_BYPASS;
`endif

    tap_state_t          state_s;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic                bypass_q, bypass_d;
    logic                chain_sel_s;
    logic                idcode_sel_s;
    logic                dr_tdo_s;
    logic                in_tlr_s;

    tap_fsm u_tap_fsm (
        .tck    (tck),
        .trst_n (trst_n),
        .tms    (tms),
        .state  (state_s)
    );

    assign in_tlr_s    = (state_s == TEST_LOGIC_RESET);
    assign chain_sel_s = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE);

    // IR and bypass next-state; IR only changes as a whole in UPDATE_IR or TEST_LOGIC_RESET.
    always_comb begin
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        bypass_d   = bypass_q;
        case (state_s)
            TEST_LOGIC_RESET: begin
                ir_d       = IR_RESET;
                ir_shift_d = '0;
            end
            CAPTURE_IR: ir_shift_d = IR_CAPTURE;
            SHIFT_IR:   ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
            UPDATE_IR:  ir_d       = ir_shift_q;
            CAPTURE_DR: bypass_d   = 1'b0;
            SHIFT_DR:   bypass_d   = tdi;
            default:    ;
        endcase
    end

    // IR and bypass registers.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_q       <= IR_RESET;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            bypass_q   <= bypass_d;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] id_q, id_d;

    assign idcode_sel_s = (ir_q == IR_IDCODE);

    // ID register captures the device ID and shifts LSB-first while selected.
    always_comb begin
        id_d = id_q;
        if (idcode_sel_s && (state_s == CAPTURE_DR)) begin
            id_d = IDCODE_VALUE;
        end else if (idcode_sel_s && (state_s == SHIFT_DR)) begin
            id_d = {tdi, id_q[31:1]};
        end else begin
            id_d = id_q;
        end
    end

    // ID register storage.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            id_q <= 32'h0000_0000;
        end else begin
            id_q <= id_d;
        end
    end
`else
    assign idcode_sel_s = 1'b0;
`endif

    // Selected data register serial output.
    always_comb begin
        dr_tdo_s = bypass_q;
        if (chain_sel_s) begin
            dr_tdo_s = bsc_s_o;
`ifdef JTAG_IDCODE_EN
        end else if (idcode_sel_s) begin
            dr_tdo_s = id_q[0];
`endif
        end else begin
            dr_tdo_s = bypass_q;
        end
    end

    // Chain strobes follow the state; enable/mode also need the instruction and are off in reset.
    always_comb begin
        bsc_clock_dr  = (state_s == CAPTURE_DR) || (state_s == SHIFT_DR);
        bsc_shift_dr  = (state_s == SHIFT_DR);
        bsc_update_dr = (state_s == UPDATE_DR);
        bsc_enable    = chain_sel_s && !in_tlr_s;
        bsc_mode      = (ir_q == IR_EXTEST) && !in_tlr_s;
        tdo_en        = (state_s == SHIFT_DR) || (state_s == SHIFT_IR);
        if (state_s == SHIFT_IR) begin
            tdo = ir_shift_q[0];
        end else begin
            tdo = dr_tdo_s;
        end
    end

    assign bsc_s_i  = tdi;
    assign ir_value = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: directed TAP scenarios plus a random TMS/TDI walk
// compared every cycle against a table-driven behavioural model of the TAP.
module tb_jtag_tap_ctrl;

    localparam int IRW = 4;
`ifdef JTAG_IDCODE_EN
    localparam logic [3:0] RST_OP = 4'h2;
`else
    localparam logic [3:0] RST_OP = 4'hF;
`endif
    localparam logic [31:0] IDV = 32'h1000_0001;

    // Model state numbering: 0 TLR,1 RTI,2 SELDR,3 CAPDR,4 SHDR,5 EX1DR,6 PDR,7 EX2DR,8 UPDDR,
    // 9 SELIR,10 CAPIR,11 SHIR,12 EX1IR,13 PIR,14 EX2IR,15 UPDIR. Entry [s] = '{next@tms0, next@tms1}.
    int nxt [16][2] = '{'{1,0}, '{1,2}, '{3,9}, '{4,5}, '{4,5}, '{6,8}, '{6,7}, '{4,8},
                        '{1,2}, '{10,0}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};

    logic tck = 1'b0;
    logic trst_n, tms, tdi, bsc_s_o;
    logic tdo, tdo_en, bsc_s_i, bsc_clock_dr, bsc_shift_dr, bsc_update_dr, bsc_enable, bsc_mode;
    logic [IRW-1:0] ir_value;

    int checks = 0;
    int errors = 0;

    int          st;
    logic [3:0]  m_ir, m_irs;
    logic        m_byp;
    logic [31:0] m_id;

    logic s_tdo, s_clk, s_sh, s_upd, s_en;

    jtag_tap_ctrl #(.IR_WIDTH(IRW), .IDCODE_VALUE(IDV)) dut (
        .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .bsc_s_i(bsc_s_i), .bsc_s_o(bsc_s_o), .bsc_clock_dr(bsc_clock_dr),
        .bsc_shift_dr(bsc_shift_dr), .bsc_update_dr(bsc_update_dr), .bsc_enable(bsc_enable),
        .bsc_mode(bsc_mode), .ir_value(ir_value)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_chain();
        return (m_ir == 4'h0) || (m_ir == 4'h1);
    endfunction

    function automatic logic m_idsel();
`ifdef JTAG_IDCODE_EN
        return m_ir == 4'h2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        st = 0; m_ir = RST_OP; m_irs = 4'h0; m_byp = 1'b0;
    endtask

    task automatic check_outputs();
        chk("tdo_en", 32'(tdo_en), 32'(st == 4 || st == 11));
        chk("clock_dr", 32'(bsc_clock_dr), 32'(st == 3 || st == 4));
        chk("shift_dr", 32'(bsc_shift_dr), 32'(st == 4));
        chk("update_dr", 32'(bsc_update_dr), 32'(st == 8));
        chk("enable", 32'(bsc_enable), 32'(m_chain() && st != 0));
        chk("mode", 32'(bsc_mode), 32'(m_ir == 4'h0 && st != 0));
        chk("ir_value", 32'(ir_value), 32'(m_ir));
        chk("bsc_s_i", 32'(bsc_s_i), 32'(tdi));
        if (st == 11) chk("tdo_ir", 32'(tdo), 32'(m_irs[0]));
        if (st == 4) chk("tdo_dr", 32'(tdo),
                         32'(m_chain() ? bsc_s_o : (m_idsel() ? m_id[0] : m_byp)));
    endtask

    task automatic model_update(input logic t, input logic d);
        case (st)
            0:  begin m_ir = RST_OP; m_irs = 4'h0; end
            10: m_irs = 4'b0001;
            11: m_irs = {d, m_irs[3:1]};
            15: m_ir = m_irs;
            3:  begin m_byp = 1'b0; if (m_idsel()) m_id = IDV; end
            4:  begin m_byp = d; if (m_idsel()) m_id = {d, m_id[31:1]}; end
            default: ;
        endcase
        st = nxt[st][t];
    endtask

    // One TCK cycle: drive at the falling edge, check, then advance the model on the rising edge.
    task automatic step(input logic t, input logic d);
        tms = t; tdi = d; bsc_s_o = 1'($urandom_range(0, 1));
        #1;
        check_outputs();
        s_tdo = tdo; s_clk = bsc_clock_dr; s_sh = bsc_shift_dr; s_upd = bsc_update_dr; s_en = bsc_enable;
        @(posedge tck);
        model_update(t, d);
        @(negedge tck);
    endtask

    task automatic async_reset();
        trst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_bsc", 32'({bsc_clock_dr, bsc_shift_dr, bsc_update_dr, bsc_enable, bsc_mode, tdo_en}), 32'h0);
        chk("rst_ir", 32'(ir_value), 32'(RST_OP));
        #2 trst_n = 1'b1;
        @(negedge tck);
    endtask

    task automatic goto_idle();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic shift_ir(input logic [3:0] v, output logic [3:0] seen);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i]);
            seen[i] = s_tdo;
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] data, output logic [31:0] seen,
                            output int n_clk, output int n_sh, output int n_upd, output int n_en);
        seen = '0; n_clk = 0; n_sh = 0; n_upd = 0; n_en = 0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0); n_clk += int'(s_clk);
        step(1'b0, 1'b0); n_clk += int'(s_clk); n_en += int'(s_en);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, data[i]);
            seen[i] = s_tdo;
            n_clk += int'(s_clk); n_sh += int'(s_sh); n_upd += int'(s_upd); n_en += int'(s_en);
        end
        step(1'b1, 1'b0); n_clk += int'(s_clk); n_sh += int'(s_sh); n_upd += int'(s_upd);
        step(1'b0, 1'b0); n_upd += int'(s_upd);
    endtask

    initial begin
        logic [3:0]  irseen;
        logic [31:0] seen;
        int nc, ns, nu, ne;

        trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; bsc_s_o = 1'b0; m_id = 32'h0;
        model_reset();
        @(negedge tck);
        #1;
        chk("reset_ir", 32'(ir_value), 32'(RST_OP));
        chk("reset_tdo_en", 32'(tdo_en), 32'h0);
        trst_n = 1'b1;
        @(negedge tck);

        // IDCODE (or bypass) serialised straight after reset.
        step(1'b0, 1'b0);
        shift_dr(32, 32'h0, seen, nc, ns, nu, ne);
`ifdef JTAG_IDCODE_EN
        chk("idcode_out", seen, 32'h1000_0001);
`else
        chk("idcode_out", seen, 32'h0);
`endif

        // Load EXTEST: capture pattern leaves on TDO, mode asserts after update.
        shift_ir(4'h0, irseen);
        chk("ir_capture", 32'(irseen), 32'h1);
        chk("extest_ir", 32'(ir_value), 32'h0);
        chk("extest_mode", 32'(bsc_mode), 32'h1);
        shift_dr(4, 32'b1101, seen, nc, ns, nu, ne);
        chk("extest_clk", 32'(nc), 32'd5);
        chk("extest_shift", 32'(ns), 32'd4);
        chk("extest_upd", 32'(nu), 32'd1);
        chk("extest_en", 32'(ne), 32'd5);

        // Five TMS=1 edges from Run-Test/Idle return to TEST_LOGIC_RESET and reload the IR.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        #1;
        chk("tms_reset_ir", 32'(ir_value), 32'(RST_OP));
        chk("tms_reset_mode", 32'(bsc_mode), 32'h0);
        @(negedge tck);
        step(1'b0, 1'b0);

        // BYPASS: one-cycle delay, first bit is the captured zero.
        shift_ir(4'hF, irseen);
        shift_dr(8, 32'hA5, seen, nc, ns, nu, ne);
        chk("bypass_out", seen, 32'h4A);
        chk("bypass_en", 32'(ne), 32'd0);

        // Async reset while part way through SHIFT_DR.
        shift_ir(4'h1, irseen);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
        async_reset();

        // Random walk through the whole state space.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        goto_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
